// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the instruction SRAM handshake one
// request at a time, and hands {ce, pc} plus the buffered word to decode.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] if_inst,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_e;

  localparam logic STOP = 1'b1;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_target_q, br_target_d;

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;
  logic        handoff;
  logic        unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign unused_stall = ^{stall[5:2], stall[0]};
  assign handoff      = (state_q == VALID) && (stall[1] != STOP);

  // A pending branch wins over a same-cycle br_e: the pending one is older.
  assign next_pc = br_pend_q ? br_target_q :
                   br_e      ? br_addr     :
                               pc_q + 32'd4;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_buf_q  <= 32'd0;
      br_pend_q   <= 1'b0;
      br_target_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_buf_q  <= inst_buf_d;
      br_pend_q   <= br_pend_d;
      br_target_q <= br_target_d;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_buf_d  = inst_buf_q;
    br_pend_d   = br_pend_q;
    br_target_d = br_target_q;

    if (br_e) begin
      br_pend_d   = 1'b1;
      br_target_d = br_addr;
    end

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (inst_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (inst_data_ok) begin
          inst_buf_d = inst_rdata;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (handoff) begin
          pc_d      = next_pc;
          state_d   = REQ;
          // Handoff consumes the pending branch; a same-cycle br_e is either
          // used directly (nothing pending) or becomes the new pending one.
          br_pend_d = br_pend_q & br_e;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_req     = (state_q == REQ);
  assign inst_addr    = (state_q == REQ) ? pc_q : 32'd0;
  assign fetch_busy   = (state_q == REQ) || (state_q == WAIT);
  assign if_to_id_bus = (state_q == VALID) ? {1'b1, pc_q} : 33'd0;
  assign if_inst      = (state_q == VALID) ? inst_buf_q : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit: per-cycle stimulus rows with
// hand-computed outputs, plus a hand-written reset-in-the-middle sequence.
module tb_if_fetch_unit;

  localparam logic [31:0] P = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'd0;
  logic [32:0] br_bus = 33'd0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;
  logic        fetch_busy;

  int total = 0;
  int bad   = 0;

  if_fetch_unit #(.RESET_PC(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_bus       (br_bus),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_to_id_bus (if_to_id_bus),
    .if_inst      (if_inst),
    .fetch_busy   (fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stop;
    logic        aok;
    logic        dok;
    logic        bre;
    logic [31:0] baddr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_ce;
    logic [31:0] exp_pc;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  // Memory contents the SRAM returns for a given address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic stop, input logic aok, input logic dok, input logic bre,
                     input logic [31:0] baddr, input logic req, input logic [31:0] addr,
                     input logic ce, input logic [31:0] pc, input logic busy);
    vec_t v;
    v.stop = stop; v.aok = aok; v.dok = dok; v.bre = bre; v.baddr = baddr;
    v.exp_req = req; v.exp_addr = addr; v.exp_ce = ce; v.exp_pc = pc; v.exp_busy = busy;
    vecs.push_back(v);
  endtask

  // Shorthand rows: REQ at address a, WAIT, VALID at pc p.
  task automatic row_req(input logic aok, input logic [31:0] a);
    add(1'b0, aok, 1'b0, 1'b0, 32'd0, 1'b1, a, 1'b0, 32'd0, 1'b1);
  endtask
  task automatic row_wait(input logic dok, input logic bre, input logic [31:0] baddr);
    add(1'b0, 1'b0, dok, bre, baddr, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
  endtask
  task automatic row_valid(input logic stop, input logic bre, input logic [31:0] baddr,
                           input logic [31:0] p);
    add(stop, 1'b1, 1'b1, bre, baddr, 1'b0, 32'd0, 1'b1, p, 1'b0);
  endtask

  initial begin
    logic [31:0] pending;

    // Reset fetch, zero-wait SRAM
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);  // cycle 0: IDLE
    row_req(1'b1, P);
    row_wait(1'b1, 1'b0, 32'd0);
    row_valid(1'b0, 1'b0, 32'd0, P);
    // SRAM wait: addr_ok late by 2, data_ok late by 3
    row_req(1'b0, P + 4);
    row_req(1'b0, P + 4);
    row_req(1'b1, P + 4);
    row_wait(1'b0, 1'b0, 32'd0);
    row_wait(1'b0, 1'b0, 32'd0);
    row_wait(1'b0, 1'b0, 32'd0);
    row_wait(1'b1, 1'b0, 32'd0);
    // Decode stall for 4 cycles, then release
    for (int k = 0; k < 4; k++) row_valid(1'b1, 1'b0, 32'd0, P + 4);
    row_valid(1'b0, 1'b0, 32'd0, P + 4);
    for (int k = 2; k < 5; k++) begin
      row_req(1'b1, P + 32'(4 * k));
      row_wait(1'b1, 1'b0, 32'd0);
      row_valid(1'b0, 1'b0, 32'd0, P + 32'(4 * k));
    end
    // Branch redirect while delay slot P+14 is in WAIT
    row_req(1'b1, P + 32'h14);
    row_wait(1'b0, 1'b1, 32'h0000_1000);
    row_wait(1'b1, 1'b0, 32'd0);
    row_valid(1'b0, 1'b0, 32'd0, P + 32'h14);
    row_req(1'b1, 32'h0000_1000);
    row_wait(1'b1, 1'b0, 32'd0);
    row_valid(1'b0, 1'b0, 32'd0, 32'h0000_1000);
    // br_e in the handoff cycle with nothing pending
    row_req(1'b1, 32'h0000_1004);
    row_wait(1'b1, 1'b0, 32'd0);
    row_valid(1'b0, 1'b1, 32'h0000_2000, 32'h0000_1004);
    row_req(1'b1, 32'h0000_2000);
    row_wait(1'b1, 1'b0, 32'd0);
    row_valid(1'b0, 1'b0, 32'd0, 32'h0000_2000);
    // Two branch pulses A then B before handoff: B wins
    row_req(1'b1, 32'h0000_2004);
    row_wait(1'b1, 1'b1, 32'h0000_3000);
    row_valid(1'b1, 1'b1, 32'h0000_4000, 32'h0000_2004);
    row_valid(1'b0, 1'b0, 32'd0, 32'h0000_2004);
    row_req(1'b1, 32'h0000_4000);
    row_wait(1'b1, 1'b0, 32'd0);
    // PC wrap at the top of the address space
    row_valid(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_4000);
    row_req(1'b1, 32'hFFFF_FFFC);
    row_wait(1'b1, 1'b0, 32'd0);
    row_valid(1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC);
    row_req(1'b0, 32'h0000_0000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",  64'(inst_req), 64'd0);
    check("rst_addr", 64'(inst_addr), 64'd0);
    check("rst_bus",  64'(if_to_id_bus), 64'd0);
    check("rst_inst", 64'(if_inst), 64'd0);
    check("rst_busy", 64'(fetch_busy), 64'd0);
    rst = 1'b0;

    pending = 32'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      check($sformatf("req[%0d]", i),  64'(inst_req),   64'(v.exp_req));
      check($sformatf("addr[%0d]", i), 64'(inst_addr),  64'(v.exp_addr));
      check($sformatf("bus[%0d]", i),  64'(if_to_id_bus), 64'({v.exp_ce, v.exp_pc}));
      check($sformatf("inst[%0d]", i), 64'(if_inst),
            v.exp_ce ? 64'(mem(v.exp_pc)) : 64'd0);
      check($sformatf("busy[%0d]", i), 64'(fetch_busy), 64'(v.exp_busy));
      if (v.exp_req && v.aok) pending = v.exp_addr;
      stall        = {4'd0, v.stop, 1'b0};
      inst_addr_ok = v.aok;
      inst_data_ok = v.dok;
      inst_rdata   = mem(pending);
      br_bus       = {v.bre, v.baddr};
      @(posedge clk);
      #1;
    end

    // Reset mid-request: DUT is in REQ at address 0
    br_bus       = 33'd0;
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b0;
    @(posedge clk);
    #1;
    check("mid_wait_busy", 64'(fetch_busy), 64'd1);
    check("mid_wait_req",  64'(inst_req), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(fetch_busy), 64'd0);
    check("mid_rst_req",  64'(inst_req), 64'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    check("mid_idle_req", 64'(inst_req), 64'd0);
    @(posedge clk);
    #1;
    check("mid_req_req",  64'(inst_req), 64'd1);
    check("mid_req_addr", 64'(inst_addr), 64'(P));
    inst_addr_ok = 1'b1;
    @(posedge clk);
    #1;
    check("mid_req2_busy", 64'(fetch_busy), 64'd1);
    check("mid_req2_req",  64'(inst_req), 64'd0);
    inst_addr_ok = 1'b0;
    inst_rdata   = mem(P);
    @(posedge clk);
    #1;
    check("mid_valid_bus",  64'(if_to_id_bus), 64'({1'b1, P}));
    check("mid_valid_inst", 64'(if_inst), 64'(mem(P)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC and drives the instruction SRAM through a req/addr_ok/data_ok handshake. It buffers each returned instruction and hands `{ce, pc}` plus the instruction word to the decode stage. It also consumes the decode stage's branch bus `{br_e, br_addr}` to redirect the PC after the delay slot.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  `StallBus`  pipeline stall vector. Only bit 1 is used: `Stop` means decode does not accept this cycle.
- `br_bus`  in  33  `{br_e, br_addr}` from decode, combinational.
- `inst_req`  out  1  SRAM request valid.
- `inst_addr`  out  32  SRAM request address.
- `inst_addr_ok`  in  1  SRAM accepted the request this cycle.
- `inst_data_ok`  in  1  `inst_rdata` valid this cycle.
- `inst_rdata`  in  32  returned instruction.
- `if_to_id_bus`  out  33  `{ce, pc}`. `ce`=1 marks a valid instruction.
- `if_inst`  out  32  instruction word paired with `if_to_id_bus`.
- `fetch_busy`  out  1  high in REQ/WAIT, for the stall controller.

## Operation
- Registers:
  - `pc_r` (32)
  - `inst_buf` (32)
  - `br_pend` (1)
  - `br_target` (32)
  - `state` ∈ {IDLE, REQ, WAIT, VALID}
- State machine:
  - **IDLE**: entered only by reset. Moves to REQ on the first clock after `rst` deasserts.
  - **REQ**: `inst_req`=1, `inst_addr`=`pc_r`. Stays until `inst_addr_ok`=1, then moves to WAIT. A request is never withdrawn once raised. A `inst_data_ok` seen in REQ is stale and ignored.
  - **WAIT**: `inst_req`=0. On `inst_data_ok`=1, `inst_buf`←`inst_rdata` and the state moves to VALID.
  - **VALID**: `ce`=1, pc=`pc_r`, `if_inst`=`inst_buf`. When `stall[1]`=`NoStop`, the instruction is handed off at this edge: `pc_r`←next_pc and state←REQ. When `stall[1]`=`Stop`, all registers hold.
- next_pc:
  - `br_target` if `br_pend`=1.
  - else `br_addr` if `br_e`=1 in the handoff cycle.
  - else `pc_r`+4, 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- Branch capture:
  - Any cycle with `br_e`=1 sets `br_pend`←1 and `br_target`←`br_addr`. A repeated `br_e` while decode is stalled overwrites the target.
  - `br_pend` clears on the VALID handoff that consumes it.
  - `br_e` and handoff in the same cycle: `br_addr` is used directly and `br_pend` stays 0.
- Delay slot: the instruction being fetched or held when `br_e` rises is the delay slot. It is always delivered, never squashed.
- Outside VALID: `ce`=0, pc=0, `if_inst`=0. Decode sees a bubble.
- `fetch_busy` = (state==REQ) | (state==WAIT).

## Timing
- Reset values (asynchronous, while `rst`=1):
  - state=IDLE, `pc_r`=`RESET_PC`.
  - `inst_buf`=0, `br_pend`=0, `br_target`=0.
  - `inst_req`=0, `inst_addr`=0, `ce`=0, `if_inst`=0, `fetch_busy`=0.
- `rst` asserted mid-transaction drops any outstanding request. A late `data_ok` after reset arrives in IDLE/REQ and is ignored.
- Minimum cycles per instruction:
  - cycle 0: REQ with `addr_ok`.
  - cycle 1: WAIT with `data_ok`.
  - cycle 2: VALID, accepted.
  - cycle 3: next REQ.
  - Sustained rate is therefore 1 instruction per 3 cycles with zero-wait SRAM.
- Each extra `addr_ok` or `data_ok` wait cycle adds one cycle. Each `stall[1]`=`Stop` cycle in VALID adds one cycle.
- Only one request is outstanding at a time. `addr_ok` and `data_ok` in the same cycle never complete the same request.
- Outputs are registered-state decodes. No combinational path runs from `inst_rdata` to `if_inst`.

## Test plan
- **Reset fetch**: release `rst`, zero-wait SRAM. Required: `inst_req`=1 with `inst_addr`=BFC0_0000 in cycle 1. `ce`=1, pc=BFC0_0000 in cycle 3. Next `inst_addr`=BFC0_0004 in cycle 4.
- **SRAM wait**: hold `addr_ok` low 2 cycles, then `data_ok` 3 cycles late. Required: `inst_req` stays high with a stable address. VALID appears exactly one cycle after `data_ok`. `inst_rdata` is captured correctly.
- **Decode stall**: in VALID, hold `stall[1]`=`Stop` 4 cycles. Required: `ce`, pc and `if_inst` remain constant, `inst_req`=0, no PC advance. Release gives the next REQ at pc+4.
- **Branch redirect**: pulse `br_e`=1, `br_addr`=0000_1000 while the delay slot at pc 0x..14 is in WAIT. Required: the delay slot is delivered with `ce`=1, then the next `inst_addr`=0000_1000 and `br_pend` is cleared.
- **Simultaneous branch and handoff**: `br_e`=1 in the handoff cycle with `br_pend`=0. Required: next `inst_addr`=`br_addr`. Also apply two `br_e` pulses with targets A then B before handoff. Required: the fetch goes to B.
- **Reset mid-request**: assert `rst` in WAIT, then return `data_ok` after release. Required: the stale data is ignored and the fetch restarts at `RESET_PC`.
